// File: rtl/mux_port_arbiter.sv
// Four-way round-robin arbiter for a shared datapath port driven through a 2:1 mux tree.
// The grant is held until done, abandon or hold limit, and one dead cycle separates owners.
module mux_port_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       timeout,
  output logic [1:0] last
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [1:0]      winner;
  logic            found;
  logic [1:0]      idx;
  logic            release_now;

  // Rotating priority scan starting at ptr_q.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    valid_d     = valid_q;
    timeout_d   = 1'b0;
    last_d      = last_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    release_now = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (done || !req[sel_q]) begin
          release_now = 1'b1;
        end else if (cnt_q == CW'(MAX_HOLD - 1)) begin
          release_now = 1'b1;
          timeout_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // sel is left alone on release so the mux tree keeps a stable select.
        if (release_now) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
          last_d  = sel_q;
          ptr_d   = sel_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'b00;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= 2'b00;
      ptr_q     <= 2'b00;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign last    = last_q;

endmodule

// File: tb/tb_mux_port_arbiter.sv
// Directed bench for mux_port_arbiter: a cycle-by-cycle vector table plus
// hand-written hold-limit sequences.
module tb_mux_port_arbiter;

  localparam int MAX_HOLD = 16;
  localparam int CW       = 5;
  localparam int NVEC     = 26;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       timeout;
  logic [1:0] last;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       timeout;
    logic [1:0] last;
  } vec_t;

  vec_t vecs [NVEC];

  mux_port_arbiter #(.MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .valid   (valid),
    .timeout (timeout),
    .last    (last)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] e_gnt, input logic [1:0] e_sel,
                       input logic e_valid, input logic e_to, input logic [1:0] e_last);
    checks += 5;
    if (gnt !== e_gnt) begin
      errors++;
      $display("FAIL %s gnt: got %b want %b", name, gnt, e_gnt);
    end
    if (sel !== e_sel) begin
      errors++;
      $display("FAIL %s sel: got %0d want %0d", name, sel, e_sel);
    end
    if (valid !== e_valid) begin
      errors++;
      $display("FAIL %s valid: got %b want %b", name, valid, e_valid);
    end
    if (timeout !== e_to) begin
      errors++;
      $display("FAIL %s timeout: got %b want %b", name, timeout, e_to);
    end
    if (last !== e_last) begin
      errors++;
      $display("FAIL %s last: got %0d want %0d", name, last, e_last);
    end
    $display("%s: rst=%b req=%b done=%b -> gnt=%b sel=%0d valid=%b timeout=%b last=%0d",
             name, reset, req, done, gnt, sel, valid, timeout, last);
  endtask

  initial begin
    //            rst  req      done gnt      sel    v    to   last
    vecs[0]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0}; // reset
    vecs[1]  = '{1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0}; // single grant
    vecs[2]  = '{1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0}; // done release
    vecs[3]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0}; // idle holds
    vecs[4]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0}; // reset ptr
    vecs[5]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0}; // rr 0
    vecs[6]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0};
    vecs[7]  = '{1'b1, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0}; // rr 1
    vecs[8]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 2'd1};
    vecs[9]  = '{1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd1}; // rr 2
    vecs[10] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 2'd2};
    vecs[11] = '{1'b1, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 2'd2}; // rr 3
    vecs[12] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 2'd3};
    vecs[13] = '{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd3}; // rr wrap
    vecs[14] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0};
    vecs[15] = '{1'b1, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0}; // owner 1
    vecs[16] = '{1'b1, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0};
    vecs[17] = '{1'b1, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0};
    vecs[18] = '{1'b1, 4'b0001, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 2'd1}; // abandon
    vecs[19] = '{1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 2'd1}; // ptr=2 -> 0
    vecs[20] = '{1'b1, 4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0};
    vecs[21] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0}; // owner 2
    vecs[22] = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0};
    vecs[23] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0}; // reset mid-busy
    vecs[24] = '{1'b1, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0}; // after reset
    vecs[25] = '{1'b1, 4'b1010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 2'd1}; // ptr -> 2

    reset = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      reset = vecs[v].rst;
      req   = vecs[v].req;
      done  = vecs[v].done;
      step();
      check($sformatf("vec%0d", v), vecs[v].gnt, vecs[v].sel, vecs[v].valid,
            vecs[v].timeout, vecs[v].last);
    end

    // Hold-limit release: ptr=2, owner 2 keeps the port for exactly MAX_HOLD cycles.
    reset = 1'b1;
    done  = 1'b0;
    req   = 4'b0100;
    step();
    check("hold_c1", 4'b0100, 2'd2, 1'b1, 1'b0, 2'd1);
    for (int c = 2; c <= MAX_HOLD; c++) begin
      step();
      check($sformatf("hold_c%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0, 2'd1);
    end
    step();
    check("hold_timeout", 4'b0000, 2'd2, 1'b0, 1'b1, 2'd2);
    req = 4'b1001;
    step();
    check("hold_next_ptr3", 4'b1000, 2'd3, 1'b1, 1'b0, 2'd2);
    done = 1'b1;
    step();
    check("hold_next_done", 4'b0000, 2'd3, 1'b0, 1'b0, 2'd3);

    // done on the final hold cycle wins over the hold limit.
    done = 1'b0;
    req  = 4'b0001;
    step();
    check("edge_grant", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd3);
    for (int c = 2; c <= MAX_HOLD; c++) begin
      step();
      check($sformatf("edge_c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0, 2'd3);
    end
    done = 1'b1;
    step();
    check("edge_done_wins", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);
    done = 1'b0;
    req  = 4'b0000;
    step();
    check("edge_no_pulse", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
